bundler_set: RTL and testbench

- Parametrised, HV-wide array of saturating bipolar bundling counters that accumulates a stream of binary hypervectors and emits a binarised (majority) hypervector.
- Adds valid/ready handshakes on input and output, an explicit accumulate/output state machine, a tie-break vector for zero counters, optional auto-clear on read, and accumulation-count and saturation status.
- Sits between the encoder datapath and the associative memory / class-HV store.

---
 rtl/bundler_set.sv | 189 ++++++++++++++++++
 tb/tb_bundler_set.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bundler_set.sv
// bundler_set: array of saturating bipolar bundling counters.
//
// Accumulates a stream of binary hypervectors into HVDimension signed counters
// (+1 for a 1 bit, -1 for a 0 bit). On request it emits the majority
// (binarised) hypervector. Counter values of zero take their output bit from
// tiebreak_i.
//
// Two states:
//   StAcc : accepting input vectors.
//   StOut : holding a result until the downstream handshake.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; also drops a pending result
//   hv_i         input binary hypervector
//   hv_valid_i   hv_i valid
//   hv_ready_o   block accepts hv_i (combinational)
//   clr_i        synchronous clear of counters, count_o and sat_o
//   binarize_i   request binarisation of the current counters
//   tiebreak_i   output bit used where a counter equals zero
//   qhv_o        binarised hypervector
//   qhv_valid_o  qhv_o valid
//   qhv_ready_i  downstream accepts qhv_o
//   count_o      vectors accumulated since the last clear (saturating)
//   sat_o        sticky: a counter hit a bound since the last clear
//   counters_o   packed counters; counter i at [i*CounterWidth +: CounterWidth]

module bundler_set #(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned CounterWidth = 8,
  parameter int unsigned CountWidth   = 16,
  parameter bit          AutoClear    = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [HVDimension-1:0]               hv_i,
  input  logic                                 hv_valid_i,
  output logic                                 hv_ready_o,
  input  logic                                 clr_i,
  input  logic                                 binarize_i,
  input  logic [HVDimension-1:0]               tiebreak_i,
  output logic [HVDimension-1:0]               qhv_o,
  output logic                                 qhv_valid_o,
  input  logic                                 qhv_ready_i,
  output logic [CountWidth-1:0]                count_o,
  output logic                                 sat_o,
  output logic [HVDimension*CounterWidth-1:0]  counters_o
);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  // Two's-complement bounds and unit step for one counter.
  localparam logic [CounterWidth-1:0] CntMax = {1'b0, {(CounterWidth-1){1'b1}}};
  localparam logic [CounterWidth-1:0] CntMin = {1'b1, {(CounterWidth-1){1'b0}}};
  localparam logic [CounterWidth-1:0] CntOne = {{(CounterWidth-1){1'b0}}, 1'b1};
  localparam logic [CountWidth-1:0]   CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

  state_e                                   r_state;
  state_e                                   w_state_d;
  logic [HVDimension-1:0][CounterWidth-1:0] r_cnt;
  logic [HVDimension-1:0][CounterWidth-1:0] w_cnt_d;
  logic [HVDimension-1:0]                   w_hold;
  logic [HVDimension-1:0]                   w_qhv_d;
  logic [HVDimension-1:0]                   r_qhv;
  logic                                     r_qhv_valid;
  logic [CountWidth-1:0]                    r_count;
  logic                                     r_sat;

  logic w_hv_ready;
  logic w_accept;
  logic w_out_hs;
  logic w_bin_req;
  logic w_clear;

  // Handshake and priority decode: clr_i > binarize_i > accumulate.
  assign w_hv_ready = (r_state == StAcc) && !clr_i && !binarize_i;
  assign w_accept   = w_hv_ready && hv_valid_i;
  assign w_bin_req  = (r_state == StAcc) && binarize_i && !clr_i;
  assign w_out_hs   = (r_state == StOut) && qhv_ready_i;
  // In StOut a clear only wipes the counters; the held result stays valid.
  assign w_clear    = clr_i || (w_out_hs && AutoClear);

  // Saturating +1/-1 per counter; a blocked step is recorded in w_hold.
  always_comb begin
    w_cnt_d = r_cnt;
    w_hold  = '0;
    for (int i = 0; i < int'(HVDimension); i++) begin
      if (hv_i[i]) begin
        if (r_cnt[i] == CntMax) begin
          w_hold[i] = 1'b1;
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntOne;
        end
      end else begin
        if (r_cnt[i] == CntMin) begin
          w_hold[i] = 1'b1;
        end else begin
          w_cnt_d[i] = r_cnt[i] - CntOne;
        end
      end
    end
  end

  // Majority: sign bit decides non-zero counters, tiebreak_i decides zeros.
  always_comb begin
    w_qhv_d = '0;
    for (int i = 0; i < int'(HVDimension); i++) begin
      if (r_cnt[i] == '0) begin
        w_qhv_d[i] = tiebreak_i[i];
      end else begin
        w_qhv_d[i] = ~r_cnt[i][CounterWidth-1];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StAcc: begin
        if (w_bin_req) begin
          w_state_d = StOut;
        end
      end
      StOut: begin
        if (qhv_ready_i) begin
          w_state_d = StAcc;
        end
      end
      default: w_state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StAcc;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Counter array.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_d;
    end
  end

  // Accumulated-vector count, holds at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_count <= '0;
    end else if (w_accept && !(&r_count)) begin
      r_count <= r_count + CountOne;
    end
  end

  // Sticky saturation flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_sat <= 1'b0;
    end else if (w_accept && (|w_hold)) begin
      r_sat <= 1'b1;
    end
  end

  // Result register; held stable while waiting for the downstream handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_qhv       <= '0;
      r_qhv_valid <= 1'b0;
    end else if (w_bin_req) begin
      r_qhv       <= w_qhv_d;
      r_qhv_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_qhv_valid <= 1'b0;
    end
  end

  assign hv_ready_o  = w_hv_ready;
  assign qhv_o       = r_qhv;
  assign qhv_valid_o = r_qhv_valid;
  assign count_o     = r_count;
  assign sat_o       = r_sat;
  assign counters_o  = r_cnt;

endmodule

// File: tb/tb_bundler_set.sv
// Directed bench for bundler_set with HVDimension=8, CounterWidth=4,
// CountWidth=5, AutoClear=1. Counter i occupies nibble i of counters_o.

module tb_bundler_set;

  localparam int unsigned Hv  = 8;
  localparam int unsigned Cw  = 4;
  localparam int unsigned Nw  = 5;

  logic              clk;
  logic              rst;
  logic [Hv-1:0]     hv;
  logic              hv_valid;
  logic              hv_ready;
  logic              clr;
  logic              bin;
  logic [Hv-1:0]     tb;
  logic [Hv-1:0]     qhv;
  logic              qhv_valid;
  logic              qhv_ready;
  logic [Nw-1:0]     count;
  logic              sat;
  logic [Hv*Cw-1:0]  counters;

  int checks;
  int failures;

  bundler_set #(
    .HVDimension  (Hv),
    .CounterWidth (Cw),
    .CountWidth   (Nw),
    .AutoClear    (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .hv_i        (hv),
    .hv_valid_i  (hv_valid),
    .hv_ready_o  (hv_ready),
    .clr_i       (clr),
    .binarize_i  (bin),
    .tiebreak_i  (tb),
    .qhv_o       (qhv),
    .qhv_valid_o (qhv_valid),
    .qhv_ready_i (qhv_ready),
    .count_o     (count),
    .sat_o       (sat),
    .counters_o  (counters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hv;
    logic        vld;
    logic        clr;
    logic        bin;
    logic [7:0]  tb;
    logic        qrdy;
    logic        exp_rdy;
    logic [31:0] exp_cnt;
    logic [4:0]  exp_count;
    logic        exp_sat;
    logic        exp_qv;
    logic [7:0]  exp_qhv;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] h, input logic v, input logic c, input logic b,
                     input logic [7:0] t, input logic qr, input logic er,
                     input logic [31:0] ec, input logic [4:0] en, input logic es,
                     input logic eq, input logic [7:0] eh);
    vec_t r;
    r.hv = h; r.vld = v; r.clr = c; r.bin = b; r.tb = t; r.qrdy = qr;
    r.exp_rdy = er; r.exp_cnt = ec; r.exp_count = en; r.exp_sat = es;
    r.exp_qv = eq; r.exp_qhv = eh;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] h, input logic v, input logic c, input logic b,
                       input logic [7:0] t, input logic qr);
    hv = h; hv_valid = v; clr = c; bin = b; tb = t; qhv_ready = qr;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ec, input logic [4:0] en,
                           input logic es, input logic eq);
    chk({tag, " counters"}, 64'(counters), 64'(ec));
    chk({tag, " count"}, 64'(count), 64'(en));
    chk({tag, " sat"}, 64'(sat), 64'(es));
    chk({tag, " qvalid"}, 64'(qhv_valid), 64'(eq));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();
    chk_state("reset", 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset qhv", 64'(qhv), 64'h0);
    rst = 1'b0;
    #1;
    chk("reset ready", 64'(hv_ready), 64'h1);

    // hv vld clr bin tb qrdy | rdy counters count sat qv qhv
    // Majority: bit0 = 1,1,0, others 0,0,0.
    add(8'h01, 1, 0, 0, 8'h00, 0, 1, 32'hFFFF_FFF1, 5'd1, 0, 0, 8'h00);
    add(8'h01, 1, 0, 0, 8'h00, 0, 1, 32'hEEEE_EEE2, 5'd2, 0, 0, 8'h00);
    add(8'h00, 1, 0, 0, 8'h00, 0, 1, 32'hDDDD_DDD1, 5'd3, 0, 0, 8'h00);
    add(8'h00, 0, 0, 1, 8'hFF, 0, 0, 32'hDDDD_DDD1, 5'd3, 0, 1, 8'h01);
    add(8'hFF, 1, 0, 0, 8'h00, 0, 0, 32'hDDDD_DDD1, 5'd3, 0, 1, 8'h01);
    add(8'h00, 0, 0, 0, 8'h00, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);
    // Tie on bit0 with tiebreak 1, then with tiebreak 0.
    add(8'h01, 1, 0, 0, 8'h00, 0, 1, 32'hFFFF_FFF1, 5'd1, 0, 0, 8'h00);
    add(8'h00, 1, 0, 0, 8'h00, 0, 1, 32'hEEEE_EEE0, 5'd2, 0, 0, 8'h00);
    add(8'h00, 0, 0, 1, 8'h01, 0, 0, 32'hEEEE_EEE0, 5'd2, 0, 1, 8'h01);
    add(8'h00, 0, 0, 0, 8'h00, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);
    add(8'h01, 1, 0, 0, 8'h00, 0, 1, 32'hFFFF_FFF1, 5'd1, 0, 0, 8'h00);
    add(8'h00, 1, 0, 0, 8'h00, 0, 1, 32'hEEEE_EEE0, 5'd2, 0, 0, 8'h00);
    add(8'h00, 0, 0, 1, 8'hFE, 0, 0, 32'hEEEE_EEE0, 5'd2, 0, 1, 8'h00);
    add(8'h00, 0, 0, 0, 8'h00, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);
    // Binarise an empty accumulator: result equals tiebreak.
    add(8'h00, 0, 0, 1, 8'hA5, 0, 0, 32'h0000_0000, 5'd0, 0, 1, 8'hA5);
    add(8'h00, 0, 0, 0, 8'h00, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);
    // Priority: clr beats binarize and input; then binarize beats input.
    add(8'hFF, 1, 0, 0, 8'h00, 0, 1, 32'h1111_1111, 5'd1, 0, 0, 8'h00);
    add(8'hFF, 1, 1, 1, 8'h00, 0, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);
    add(8'hF0, 1, 0, 0, 8'h00, 0, 1, 32'h1111_FFFF, 5'd1, 0, 0, 8'h00);
    add(8'hFF, 1, 0, 1, 8'h00, 0, 0, 32'h1111_FFFF, 5'd1, 0, 1, 8'hF0);
    // Clear in OUT keeps the result; clear plus handshake together.
    add(8'h00, 0, 1, 0, 8'h00, 0, 0, 32'h0000_0000, 5'd0, 0, 1, 8'hF0);
    add(8'h00, 0, 1, 0, 8'h00, 1, 0, 32'h0000_0000, 5'd0, 0, 0, 8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(vq[i].hv, vq[i].vld, vq[i].clr, vq[i].bin, vq[i].tb, vq[i].qrdy);
      #1;
      chk({tag, " ready"}, 64'(hv_ready), 64'(vq[i].exp_rdy));
      tick();
      chk_state(tag, vq[i].exp_cnt, vq[i].exp_count, vq[i].exp_sat, vq[i].exp_qv);
      if (vq[i].exp_qv) begin
        chk({tag, " qhv"}, 64'(qhv), 64'(vq[i].exp_qhv));
      end
    end

    // Saturation: +7 is reached after 7 ones without a hold; the 8th sets sat.
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk_state("sat7", 32'h7777_7777, 5'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_state("sat10", 32'h7777_7777, 5'd10, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk_state("neg20", 32'h8888_8888, 5'd30, 1'b1, 1'b0);
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk_state("count31", 32'h9999_9999, 5'd31, 1'b1, 1'b0);
    tick();
    chk_state("count_hold", 32'hAAAA_AAAA, 5'd31, 1'b1, 1'b0);

    // Back-pressure: result and counters frozen while qhv_ready is low.
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    chk_state("bp_bin", 32'hFFFF_1111, 5'd1, 1'b0, 1'b1);
    chk("bp_bin qhv", 64'(qhv), 64'h0F);
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("bp%0d", i);
      chk({tag, " ready"}, 64'(hv_ready), 64'h0);
      tick();
      chk_state(tag, 32'hFFFF_1111, 5'd1, 1'b0, 1'b1);
      chk({tag, " qhv"}, 64'(qhv), 64'h0F);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk_state("bp_release", 32'h0, 5'd0, 1'b0, 1'b0);
    idle();
    #1;
    chk("bp_release ready", 64'(hv_ready), 64'h1);

    // Reset while a result is pending.
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    chk_state("pre_rst", 32'h7777_7777, 5'd8, 1'b1, 1'b1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("rst_out", 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_out ready", 64'(hv_ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
